sram_1p_req_ctrl: RTL and testbench

- Request-side controller sitting directly upstream of the 64x32 single-port SRAM macro.
- Converts a valid/ready request stream (read or write) into the macro's active-low CEB/WEB/A/D pin protocol.
- Samples Q only in the cycle after a read. Outside that cycle the macro's Q output is garbage.
- Returns read data through a small response FIFO with its own valid/ready backpressure.

---
 rtl/sram_1p_req_ctrl.sv | 127 ++++++++++++
 tb/tb_sram_1p_req_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1p_req_ctrl.sv
// Request-side controller for a single-port 64x32 SRAM macro: valid/ready requests in, CEB/WEB/A/D pins out,
// read data returned through a credit-protected response FIFO. Define SRAM_INIT_EN to zero the macro after reset.
module sram_1p_req_ctrl #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 64,
  parameter int ADD_WIDTH  = 6,
  parameter int RESP_DEPTH = 3
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADD_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]      req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BITS-1:0]      resp_rdata,
  output logic                 sram_ceb,
  output logic                 sram_web,
  output logic [ADD_WIDTH-1:0] sram_a,
  output logic [BITS-1:0]      sram_d,
  input  logic [BITS-1:0]      sram_q
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RESP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RESP_DEPTH - 1);

  if (ADD_WIDTH != $clog2(WORD_DEPTH) || RESP_DEPTH < 2) begin : g_bad_cfg
    $error("sram_1p_req_ctrl: ADD_WIDTH must be log2(WORD_DEPTH) and RESP_DEPTH at least 2");
  end

  typedef enum logic {INIT, RUN} state_t;

`ifdef SRAM_INIT_EN
  localparam state_t RST_STATE = INIT;
  localparam logic [ADD_WIDTH-1:0] ADDR_LAST = ADD_WIDTH'(WORD_DEPTH - 1);
  logic [ADD_WIDTH-1:0] init_addr;
`else
  localparam state_t RST_STATE = RUN;
`endif

  state_t          state, state_nxt;
  logic            rd_inflight, fire, push, pop;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  logic [BITS-1:0] fifo_mem [RESP_DEPTH];

  // Reads still in the macro pipe count against FIFO space so a returning word always has a slot.
  assign credit     = {1'b0, count} + {{CW{1'b0}}, rd_inflight};
  assign push       = rd_inflight;
  assign pop        = resp_valid && resp_ready;
  assign resp_valid = (count != '0);
  assign resp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= RST_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    fire      = 1'b0;
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    case (state)
      INIT: begin
`ifdef SRAM_INIT_EN
        if (RSTB) begin
          sram_ceb = 1'b0;
          sram_web = 1'b0;
          sram_a   = init_addr;
          if (init_addr == ADDR_LAST) state_nxt = RUN;
        end
`else
        state_nxt = RUN;
`endif
      end
      default: begin
        // RSTB gating keeps the pins idle and ready low while reset is held.
        req_ready = RSTB && (req_write || (credit < DEPTH_C));
        fire      = req_valid && req_ready;
        if (fire) begin
          sram_ceb = 1'b0;
          sram_web = !req_write;
          sram_a   = req_addr;
          sram_d   = req_wdata;
        end
      end
    endcase
  end

`ifdef SRAM_INIT_EN
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)              init_addr <= '0;
    else if (state == INIT) init_addr <= init_addr + ADD_WIDTH'(1);
  end
`endif

  // Issue stage -> macro access stage: remember a read so Q is captured only in the following cycle.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      rd_inflight <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      rd_inflight <= fire && !req_write;
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Macro access stage -> response FIFO: data storage carries no reset.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= sram_q;
  end

endmodule

// File: tb/tb_sram_1p_req_ctrl.sv
// Randomized self-checking bench for sram_1p_req_ctrl with a behavioural macro and a queue-based response model.
module tb_sram_1p_req_ctrl;
  localparam int BITS = 32, WORD_DEPTH = 64, ADD_WIDTH = 6, RESP_DEPTH = 3;

  logic                 CLK = 1'b0, RSTB = 1'b0;
  logic                 req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [ADD_WIDTH-1:0] req_addr = '0;
  logic [BITS-1:0]      req_wdata = '0;
  logic                 req_ready, resp_valid, sram_ceb, sram_web;
  logic [BITS-1:0]      resp_rdata, sram_d, sram_q;
  logic [ADD_WIDTH-1:0] sram_a;

  always #5 CLK = ~CLK;

  sram_1p_req_ctrl #(.BITS(BITS), .WORD_DEPTH(WORD_DEPTH), .ADD_WIDTH(ADD_WIDTH), .RESP_DEPTH(RESP_DEPTH)) dut (
    .CLK(CLK), .RSTB(RSTB), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  // Macro model: Q is meaningful only the cycle after a read, random garbage otherwise.
  logic [BITS-1:0] mac_mem [WORD_DEPTH];
  logic [BITS-1:0] mac_q = '0, garbage = '0;
  logic            mac_rd = 1'b0;
  always @(posedge CLK) begin
    mac_rd  <= !sram_ceb && sram_web;
    if (!sram_ceb && !sram_web) mac_mem[sram_a] <= sram_d;
    if (!sram_ceb && sram_web)  mac_q <= mac_mem[sram_a];
    garbage <= $urandom;
  end
  assign sram_q = mac_rd ? mac_q : garbage;

  // Reference model: memory contents plus ordered outstanding reads with the cycle they become visible.
  typedef struct { logic [BITS-1:0] data; int avail; } resp_t;
  resp_t           exp_q[$];
  logic [BITS-1:0] ref_mem [WORD_DEPTH];
  int cyc = 0, errors = 0, checks = 0;

  function automatic bit m_ready(input bit w);
    return w || (exp_q.size() < RESP_DEPTH);
  endfunction

  function automatic bit m_valid();
    return (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
  endfunction

  task automatic drive(input bit v, input bit w, input int a, input logic [BITS-1:0] d, input bit rr);
    req_valid = v; req_write = w; req_addr = ADD_WIDTH'(a); req_wdata = d; resp_ready = rr;
  endtask

  task automatic advance();
    bit f, p;
    resp_t e;
    f = req_valid && m_ready(req_write);
    p = m_valid() && resp_ready;
    if (p) void'(exp_q.pop_front());
    if (f && req_write) ref_mem[req_addr] = req_wdata;
    if (f && !req_write) begin
      e.data = ref_mem[req_addr]; e.avail = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge CLK); cyc++; #1;
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    drive(1, 0, 7, 32'h1234_5678, 1);
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", resp_valid); end
    checks++; if (sram_ceb !== 1'b1) begin errors++; $display("FAIL rst_ceb got=%b want=1", sram_ceb); end
    checks++; if (sram_web !== 1'b1) begin errors++; $display("FAIL rst_web got=%b want=1", sram_web); end
    checks++; if (sram_a !== '0) begin errors++; $display("FAIL rst_a got=%h want=0", sram_a); end
    checks++; if (sram_d !== '0) begin errors++; $display("FAIL rst_d got=%h want=0", sram_d); end
    @(posedge CLK); #1;
    RSTB = 1'b1;
    exp_q.delete();
    drive(0, 0, 7, '0, 1);
`ifndef SRAM_INIT_EN
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL first_ready got=%b want=1", req_ready); end
    advance();
`endif
  endtask

`ifdef SRAM_INIT_EN
  task automatic test_init();
    for (int i = 0; i < WORD_DEPTH; i++) begin
      #2;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL init_ready[%0d] got=%b want=0", i, req_ready); end
      checks++; if ({sram_ceb, sram_web} !== 2'b00) begin errors++; $display("FAIL init_pins[%0d] got=%b want=00", i, {sram_ceb, sram_web}); end
      checks++; if (sram_a !== ADD_WIDTH'(i)) begin errors++; $display("FAIL init_a got=%0d want=%0d", sram_a, i); end
      checks++; if (sram_d !== '0) begin errors++; $display("FAIL init_d got=%h want=0", sram_d); end
      advance();
    end
    for (int i = 0; i < WORD_DEPTH; i++) ref_mem[i] = '0;
    drive(1, 0, 63, '0, 1);
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL init_done_ready got=%b want=1", req_ready); end
    advance();
    drive(0, 0, 0, '0, 1);
    advance();
    #2;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL init_rd_valid got=%b want=1", resp_valid); end
    checks++; if (resp_rdata !== '0) begin errors++; $display("FAIL init_rd_data got=%h want=0", resp_rdata); end
    advance();
  endtask
`endif

  task automatic test_write_read();
    drive(1, 1, 5, 32'hDEAD_BEEF, 1);
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got=%b want=1", req_ready); end
    checks++; if ({sram_ceb, sram_web, sram_a, sram_d} !== {2'b00, 6'd5, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL wr_pins got=%b%b a=%h d=%h want=00 a=05 d=deadbeef", sram_ceb, sram_web, sram_a, sram_d); end
    advance();
    drive(1, 0, 5, '0, 1);
    #2;
    checks++; if ({sram_ceb, sram_web, sram_a} !== {2'b01, 6'd5})
      begin errors++; $display("FAIL rd_pins got=%b%b a=%h want=01 a=05", sram_ceb, sram_web, sram_a); end
    advance();
    drive(0, 0, 0, '0, 1);
    #2;
    checks++; if ({sram_ceb, resp_valid} !== 2'b10) begin errors++; $display("FAIL rd_n1 got ceb,valid=%b want=10", {sram_ceb, resp_valid}); end
    advance();
    #2;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_n2_valid got=%b want=1", resp_valid); end
    checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_n2_data got=%h want=deadbeef", resp_rdata); end
    advance();
    #2;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_n3_valid got=%b want=0", resp_valid); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [BITS-1:0] seen[$];
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, i, BITS'(i * 3), 1);
      advance();
    end
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(1, 0, k, '0, 1); else drive(0, 0, 0, '0, 1);
      #2;
      if (k < 8) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b want=1", k, req_ready); end
      end
      checks++; if (resp_valid !== m_valid()) begin errors++; $display("FAIL b2b_valid[%0d] got=%b want=%b", k, resp_valid, m_valid()); end
      if (resp_valid === 1'b1) seen.push_back(resp_rdata);
      advance();
    end
    checks++; if (seen.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", seen.size()); end
    for (int j = 0; j < seen.size() && j < 8; j++) begin
      checks++; if (seen[j] !== BITS'(j * 3)) begin errors++; $display("FAIL b2b_data[%0d] got=%h want=%h", j, seen[j], j * 3); end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, drained = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, $urandom_range(0, 7), '0, 0);
      #2;
      checks++; if (req_ready !== m_ready(0)) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=%b", k, req_ready, m_ready(0)); end
      if (req_ready === 1'b1) acc++;
      advance();
    end
    checks++; if (acc != RESP_DEPTH) begin errors++; $display("FAIL bp_accepted got=%0d want=%0d", acc, RESP_DEPTH); end
    drive(1, 1, 40, $urandom, 0);
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_write_ready got=%b want=1", req_ready); end
    advance();
    drive(1, 0, 1, '0, 0);
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_read_blocked got=%b want=0", req_ready); end
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, '0, 1);
      #2;
      checks++; if (resp_valid !== m_valid()) begin errors++; $display("FAIL bp_drain_valid[%0d] got=%b want=%b", k, resp_valid, m_valid()); end
      if (m_valid()) begin
        drained++;
        checks++; if (resp_rdata !== exp_q[0].data) begin errors++; $display("FAIL bp_drain_data[%0d] got=%h want=%h", k, resp_rdata, exp_q[0].data); end
      end
      advance();
    end
    checks++; if (drained != RESP_DEPTH) begin errors++; $display("FAIL bp_drained got=%0d want=%0d", drained, RESP_DEPTH); end
  endtask

  task automatic test_idle_hold();
    logic [BITS-1:0] want;
    want = ref_mem[2];
    drive(1, 0, 2, '0, 0);
    advance();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, '0, 0);
      #2;
      checks++; if (resp_valid !== (k >= 1)) begin errors++; $display("FAIL hold_valid[%0d] got=%b want=%b", k, resp_valid, k >= 1); end
      if (k >= 1) begin
        checks++; if (resp_rdata !== want) begin errors++; $display("FAIL hold_data[%0d] got=%h want=%h", k, resp_rdata, want); end
      end
      advance();
    end
    drive(0, 0, 0, '0, 1);
    advance();
    for (int k = 0; k < 5; k++) begin
      #2;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d] got=%b want=0", k, resp_valid); end
      advance();
    end
  endtask

  task automatic test_random();
    bit v, w, rr, er, ef;
    int a;
    logic [BITS-1:0] d;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom % 4) != 0; w = $urandom % 2; rr = ($urandom % 3) != 0;
      a = $urandom_range(0, WORD_DEPTH - 1); d = $urandom;
      drive(v, w, a, d, rr);
      #2;
      er = m_ready(w); ef = v && er;
      checks++; if (req_ready !== er) begin errors++; $display("FAIL rnd_ready[%0d] got=%b want=%b", k, req_ready, er); end
      checks++;
      if (ef && {sram_ceb, sram_web, sram_a, sram_d} !== {1'b0, !w, ADD_WIDTH'(a), d}) begin
        errors++; $display("FAIL rnd_pins[%0d] got=%b%b a=%h d=%h want=0%b a=%h d=%h", k, sram_ceb, sram_web, sram_a, sram_d, !w, a, d);
      end else if (!ef && {sram_ceb, sram_web, sram_a, sram_d} !== {2'b11, {ADD_WIDTH{1'b0}}, {BITS{1'b0}}}) begin
        errors++; $display("FAIL rnd_idle_pins[%0d] got=%b%b a=%h d=%h want idle", k, sram_ceb, sram_web, sram_a, sram_d);
      end
      checks++; if (resp_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid[%0d] got=%b want=%b", k, resp_valid, m_valid()); end
      if (m_valid()) begin
        checks++; if (resp_rdata !== exp_q[0].data) begin errors++; $display("FAIL rnd_data[%0d] got=%h want=%h", k, resp_rdata, exp_q[0].data); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, '0, 1);
    repeat (6) advance();
    drive(1, 0, 5, '0, 1);
    advance();
    RSTB = 1'b0;
    drive(1, 0, 6, '0, 1);
    #2;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b want=0", resp_valid); end
    checks++; if ({sram_ceb, sram_web} !== 2'b11) begin errors++; $display("FAIL mid_rst_pins got=%b want=11", {sram_ceb, sram_web}); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b want=0", req_ready); end
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RSTB = 1'b1;
    exp_q.delete();
    drive(0, 0, 0, '0, 1);
`ifdef SRAM_INIT_EN
    repeat (WORD_DEPTH) advance();
`endif
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid[%0d] got=%b want=0", k, resp_valid); end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < WORD_DEPTH; i++) begin
      mac_mem[i] = '0;
      ref_mem[i] = '0;
    end
    @(posedge CLK); #1;
    test_reset();
`ifdef SRAM_INIT_EN
    test_init();
`endif
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_idle_hold();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
